// File: rtl/xvga_timing_if.sv
// Raster timing bundle driven by xvga_timing and consumed by the pixel pipeline.
interface xvga_timing_if;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hsync;
  logic        vsync;
  logic        blank;
  logic        frame_start;
  logic [7:0]  frame_count;

  modport master (
    output hcount, vcount, hsync, vsync, blank, frame_start, frame_count
  );

  modport slave (
    input hcount, vcount, hsync, vsync, blank, frame_start, frame_count
  );
endinterface

// File: rtl/xvga_timing.sv
// 1024x768@60 raster generator: pixel/line counters, active-low syncs, blank, frame marker.
// Define XVGA_SYNC_DELAY_EN to lag hsync/vsync/blank by one clock behind the counters.
module xvga_timing #(
  parameter int unsigned H_ACTIVE = 1024,
  parameter int unsigned H_FP     = 24,
  parameter int unsigned H_SYNC   = 136,
  parameter int unsigned H_BP     = 160,
  parameter int unsigned V_ACTIVE = 768,
  parameter int unsigned V_FP     = 3,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 29
) (
  input  logic          pixel_clk,
  input  logic          reset,
  xvga_timing_if.master vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_VIS_END    = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_FIRST = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);

  localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_VIS_END    = 10'(V_ACTIVE);
  localparam logic [9:0]  V_SYNC_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  V_SYNC_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [10:0] hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        blank_q, blank_d;
  logic        frame_start_q, frame_start_d;
  logic [7:0]  frame_count_q, frame_count_d;

  always_comb begin
    hcount_d      = hcount_q + 11'd1;
    vcount_d      = vcount_q;
    frame_start_d = 1'b0;
    frame_count_d = frame_count_q;

    if (hcount_q == H_LAST) begin
      hcount_d = 11'd0;
      if (vcount_q == V_LAST) begin
        vcount_d      = 10'd0;
        frame_start_d = 1'b1;
        frame_count_d = frame_count_q + 8'd1;
      end else begin
        vcount_d = vcount_q + 10'd1;
      end
    end

    // Decode from the next-state counts so the registered flags line up with the counters.
    hsync_d = !((hcount_d >= H_SYNC_FIRST) && (hcount_d <= H_SYNC_LAST));
    vsync_d = !((vcount_d >= V_SYNC_FIRST) && (vcount_d <= V_SYNC_LAST));
    blank_d = (hcount_d >= H_VIS_END) || (vcount_d >= V_VIS_END);
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      hcount_q      <= 11'd0;
      vcount_q      <= 10'd0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      blank_q       <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_q       <= blank_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

`ifdef XVGA_SYNC_DELAY_EN
  // Extra stage matches the one-cycle pixel latency of the downstream renderer.
  logic hsync_dly_q, vsync_dly_q, blank_dly_q;

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      hsync_dly_q <= 1'b1;
      vsync_dly_q <= 1'b1;
      blank_dly_q <= 1'b0;
    end else begin
      hsync_dly_q <= hsync_q;
      vsync_dly_q <= vsync_q;
      blank_dly_q <= blank_q;
    end
  end

  assign vga.hsync = hsync_dly_q;
  assign vga.vsync = vsync_dly_q;
  assign vga.blank = blank_dly_q;
`else
  assign vga.hsync = hsync_q;
  assign vga.vsync = vsync_q;
  assign vga.blank = blank_q;
`endif

  assign vga.hcount      = hcount_q;
  assign vga.vcount      = vcount_q;
  assign vga.frame_start = frame_start_q;
  assign vga.frame_count = frame_count_q;

endmodule

// File: tb/tb_xvga_timing.sv
// Scoreboard bench for xvga_timing on a shrunken raster; model works on a linear pixel index.
module tb_xvga_timing;

  localparam int HA = 10, HF = 2, HS = 4, HB = 4;
  localparam int VA = 5,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
    logic        hs;
    logic        vs;
    logic        bl;
    logic        fs;
    logic [7:0]  fc;
  } obs_t;

  logic pixel_clk = 1'b0;
  logic reset;

  xvga_timing_if vga();

  xvga_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .pixel_clk(pixel_clk),
    .reset    (reset),
    .vga      (vga)
  );

  always #5 pixel_clk = ~pixel_clk;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // model state: linear position within the frame and completed-frame total
  int   m_p = 0;
  int   m_frames = 0;
  int   m_pulses = 0;
  bit   m_wrap = 1'b0;
  logic a_hs = 1'b1, a_vs = 1'b1, a_bl = 1'b0;

  int   seen_pulses = 0;
  bit   seen_wrap = 1'b0;

  task automatic model_edge(input logic rst_v);
    obs_t e;
    int h, v;
    logic n_hs, n_vs, n_bl, d_hs, d_vs, d_bl, fs;
    fs = 1'b0;
    if (rst_v) begin
      m_p = 0;
      m_frames = 0;
      n_hs = 1'b1; n_vs = 1'b1; n_bl = 1'b0;
      d_hs = 1'b1; d_vs = 1'b1; d_bl = 1'b0;
    end else begin
      m_p = (m_p + 1) % FT;
      if (m_p == 0) begin
        fs = 1'b1;
        m_pulses++;
        if (m_frames % 256 == 255) m_wrap = 1'b1;
        m_frames++;
      end
      h = m_p % HT;
      v = m_p / HT;
      n_hs = !(h >= HA + HF && h < HA + HF + HS);
      n_vs = !(v >= VA + VF && v < VA + VF + VS);
      n_bl = (h >= HA) || (v >= VA);
      d_hs = a_hs; d_vs = a_vs; d_bl = a_bl;
    end
    a_hs = n_hs; a_vs = n_vs; a_bl = n_bl;
    e.h  = 11'(m_p % HT);
    e.v  = 10'(m_p / HT);
`ifdef XVGA_SYNC_DELAY_EN
    e.hs = d_hs; e.vs = d_vs; e.bl = d_bl;
`else
    e.hs = n_hs; e.vs = n_vs; e.bl = n_bl;
`endif
    e.fs = fs;
    e.fc = 8'(m_frames % 256);
    exp_q.push_back(e);
  endtask

  task automatic step(input logic rst_v);
    reset = rst_v;
    model_edge(rst_v);
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic reset_at(input int h, input int v);
    int n;
    n = 0;
    while (m_p != v * HT + h && n <= FT) begin
      step(1'b0);
      n++;
    end
    step(1'b1);
  endtask

  // monitor: one observation per clock, 2 time units after the edge
  initial begin
    obs_t e, got;
    forever begin
      @(posedge pixel_clk);
      #2;
      got = '{vga.hcount, vga.vcount, vga.hsync, vga.vsync, vga.blank,
              vga.frame_start, vga.frame_count};
      if (got.fs === 1'b1) begin
        seen_pulses++;
        if (got.fc === 8'd0) seen_wrap = 1'b1;
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: output present with no expected entry");
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL cycle t=%0t: got h=%0d v=%0d hs=%b vs=%b bl=%b fs=%b fc=%0d, want h=%0d v=%0d hs=%b vs=%b bl=%b fs=%b fc=%0d",
                   $time, got.h, got.v, got.hs, got.vs, got.bl, got.fs, got.fc,
                   e.h, e.v, e.hs, e.vs, e.bl, e.fs, e.fc);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1);
    for (int i = 0; i < 2 * FT + 5; i++) step(1'b0);

    reset_at(HA + HF + 1, VA + VF + 1);
    for (int i = 0; i < 30; i++) step(1'b0);
    reset_at(HT - 1, VT - 1);
    for (int i = 0; i < 30; i++) step(1'b0);

    for (int i = 0; i < 3000; i++) step($urandom_range(0, 299) == 0);

    step(1'b1);
    for (int i = 0; i < 257 * FT + 10; i++) step(1'b0);
    step(1'b0);

    #5;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    checks++;
    if (seen_pulses != m_pulses) begin
      errors++;
      $display("FAIL frame_start_pulses: saw %0d, want %0d", seen_pulses, m_pulses);
    end
    checks++;
    if (seen_wrap != m_wrap) begin
      errors++;
      $display("FAIL frame_count_wrap: saw %0b, want %0b", seen_wrap, m_wrap);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xvga_timing.md
XVGA_TIMING -- requirements
Module: xvga_timing

Interface
REQ-001 Parameter H_ACTIVE, default 1024: visible pixels per line.
REQ-002 Parameter H_FP, default 24: horizontal front porch, in clocks.
REQ-003 Parameter H_SYNC, default 136: horizontal sync width, in clocks.
REQ-004 Parameter H_BP, default 160: horizontal back porch; H_TOTAL = sum of the four horizontal parameters = 1344.
REQ-005 Parameter V_ACTIVE, default 768: visible lines per frame.
REQ-006 Parameter V_FP, default 3: vertical front porch, in lines.
REQ-007 Parameter V_SYNC, default 6: vertical sync width, in lines.
REQ-008 Parameter V_BP, default 29: vertical back porch; V_TOTAL = 806.
REQ-009 pixel_clk  in  1  single clock (65 MHz); every register is clocked on its rising edge.
REQ-010 reset  in  1  synchronous reset, active-high.
REQ-011 hcount  out  11  current pixel column, 0..H_TOTAL-1; feeds picture_blob hcount.
REQ-012 vcount  out  10  current line, 0..V_TOTAL-1; feeds picture_blob vcount.
REQ-013 hsync  out  1  horizontal sync, active-low.
REQ-014 vsync  out  1  vertical sync, active-low.
REQ-015 blank  out  1  high outside the visible area.
REQ-016 frame_start  out  1  one-cycle pulse marking pixel (0,0) of each new frame.
REQ-017 frame_count  out  8  number of completed frames, modulo 256.

Function
REQ-018 All outputs shall be registered; no combinational path from input to output.
REQ-019 hcount shall increment by 1 every clock and wrap from H_TOTAL-1 to 0.
REQ-020 vcount shall increment only on the clock where hcount wraps, and shall wrap from V_TOTAL-1 to 0 on that same clock.
REQ-021 hsync shall be 0 exactly while hcount is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (1048..1183), and 1 otherwise.
REQ-022 vsync shall be 0 exactly while vcount is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (771..776), for whole lines, and 1 otherwise.
REQ-023 blank shall be 1 exactly while hcount >= H_ACTIVE or vcount >= V_ACTIVE.
REQ-024 hsync, vsync and blank shall be computed from the next-state counts, so they align in the same cycle with the hcount/vcount values they describe (subject to REQ-031).
REQ-025 frame_start shall be 1 for exactly one cycle, in the cycle where hcount=0 and vcount=0 is reached by wrap-around.
REQ-026 frame_start shall stay 0 in the (0,0) cycle that immediately follows reset.
REQ-027 frame_count shall increment by 1 in the same cycle that frame_start asserts, and shall wrap from 255 to 0.

Reset
REQ-028 While reset=1 on a clock edge, outputs shall be: hcount=0, vcount=0, hsync=1, vsync=1, blank=0, frame_start=0, frame_count=0.
REQ-029 Reset shall take priority over counting at any point in the frame, including mid-sync and the final pixel (1343,805).
REQ-030 On the first clock after reset deasserts, hcount shall be 1 and vcount 0.

Configuration
REQ-031 With macro XVGA_SYNC_DELAY_EN defined, hsync, vsync and blank shall pass through one extra register stage, lagging hcount/vcount by one clock; this matches picture_blob's one-cycle pixel latency. The delay registers shall reset to 1/1/0. With the macro undefined, the REQ-024 alignment applies. hcount, vcount, frame_start and frame_count are unaffected either way.

Verification
REQ-032 Release reset and run 1344 clocks -> hcount runs 0..1343 then returns to 0; vcount steps 0->1 on the same clock.
REQ-033 On line 0, sample hsync -> 0 from hcount=1048 through 1183 inclusive (136 clocks); 1 at 1047 and at 1184; blank=1 from hcount=1024 through 1343.
REQ-034 Run one full frame (1,083,264 clocks) -> vsync=0 for vcount 771..776 (8064 clocks); frame_start pulses once, at the wrap to (0,0); frame_count=1.
REQ-035 Run 256 frames -> frame_count wraps 255->0, with exactly 256 frame_start pulses.
REQ-036 Assert reset for 1 clock at hcount=1100, vcount=773 -> next cycle hcount=0, vcount=0, hsync=1, vsync=1, frame_count=0, with no frame_start pulse.
REQ-037 Build with XVGA_SYNC_DELAY_EN -> hsync falls in the cycle where hcount=1049 and blank rises where hcount=1025; build without it -> edges at 1048 and 1024.
